rvh_pmp_check_sched: RTL and testbench
======================================

Name: rvh_pmp_check_sched

Overview:
- Shares one PMP permission-check port, broadcast to all PMP entries, among REQ_NUM requesters such as the ITLB-miss walker, the DTLB-miss walker and LSU bypass.
- Arbitrates round-robin and registers the winning request.
- Drives the check for one cycle, then priority-resolves the per-entry match/fail vectors: lowest-numbered matching entry wins.
- Returns a per-requester fault result over a valid/ready handshake. Sits between the MMU requesters and the PMP entry array.

Parameters:
- REQ_NUM, 3, number of requesters (≥2)
- ENTRY_NUM, 16, number of PMP entries (≥1)
- PADDR_WIDTH, 56, physical address width

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- req_vld_i  input  REQ_NUM  request valid per requester
- req_paddr_i  input  REQ_NUM*PADDR_WIDTH  packed physical address; requester k at [k*PADDR_WIDTH +: PADDR_WIDTH]
- req_access_type_i  input  REQ_NUM*2  packed access type: 0=R, 1=W, 2=X, 3=illegal
- req_priv_m_i  input  REQ_NUM  access issued in M-mode
- req_rdy_o  output  REQ_NUM  request accepted (one-hot or zero)
- resp_vld_o  output  REQ_NUM  response valid (one-hot or zero)
- resp_fault_o  output  1  access fault for the responding requester
- resp_rdy_i  input  REQ_NUM  response accepted per requester
- flush_i  input  1  abort the in-flight check
- permission_check_vld_o  output  1  check valid to entry array
- permission_check_paddr_o  output  PADDR_WIDTH  check address
- permission_check_access_type_o  output  2  check access type
- entry_match_i  input  ENTRY_NUM  per-entry range match (already gated by check valid)
- entry_fail_i  input  ENTRY_NUM  per-entry permission fail
- entry_lock_i  input  ENTRY_NUM  per-entry pmpcfg.L

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0 during and after reset. State = IDLE. RR pointer = 0. Captured request and result registers = 0.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - Grant goes to the first requester with req_vld_i set, scanning from the RR pointer upward with wrap-around.
  - req_rdy_o[grant] = 1, combinational on req_vld_i. req_rdy_o is 0 in every other state.
  - On grant: capture paddr, access type, priv_m and grant index; set RR pointer = grant+1 mod REQ_NUM; go to CHECK.
  - No valid request: stay in IDLE, pointer unchanged.
- CHECK (exactly one cycle):
  - permission_check_vld_o = 1. permission_check_paddr_o and permission_check_access_type_o come from the captured registers. Outside CHECK, vld = 0 and paddr/type are held at the captured values.
  - Resolution, same cycle: i = lowest index with entry_match_i[i] = 1.
    - No match: fault = ~priv_m.
    - Match with priv_m = 1 and entry_lock_i[i] = 0: fault = 0.
    - Otherwise: fault = entry_fail_i[i].
  - Access type 3: fault = 1 regardless of the above.
  - Register fault, then go to RESP.
- RESP:
  - resp_vld_o[captured grant] = 1; resp_fault_o = registered fault. Both held stable until resp_rdy_i[grant] = 1.
  - On acceptance: go to IDLE. No new grant in the same cycle.
- Latency:
  - Request accepted in cycle T → check in T+1 → resp_vld_o in T+2.
  - Minimum 3 cycles per request; back-to-back grants no closer than every 3 cycles.
- flush_i:
  - In CHECK or RESP: return to IDLE next cycle; no response is issued; the RR pointer keeps its advanced value.
  - In IDLE: flush_i masks all grants that cycle.
- Ignored inputs: resp_rdy_i of non-responding requesters. entry_* inputs outside CHECK.
- Requester contract: a requester must not drop req_vld_i or change its payload before acceptance. The block does not check this.
- Reset mid-operation: immediate return to IDLE; all outputs cleared asynchronously.

Test Plan:
- Single requester: req 0, paddr 0x8000_1000, type R, priv_m 0; entry 2 match, fail 0 → req_rdy_o = 001 at T, permission_check_vld_o = 1 at T+1 with paddr 0x8000_1000, resp_vld_o = 001 and resp_fault_o = 0 at T+2.
- Priority resolution: match = 0x0014, fail = 0x0010, priv_m 0 → entry 2 wins, fault = 0. Then match = 0x0010, fail = 0x0010 → fault = 1.
- M-mode rules:
  - priv_m 1, no match → fault 0.
  - priv_m 1, match entry 3 with lock 0 and fail 1 → fault 0.
  - Same but lock 1 → fault 1.
  - priv_m 0, no match → fault 1.
- Round-robin: all three requesters held valid continuously → grants in order 0,1,2,0 at 3-cycle spacing. resp_rdy_i held low for 4 cycles → resp_vld_o and resp_fault_o stay stable and no new grant occurs.
- Flush: flush_i asserted in CHECK → no resp_vld_o; next grant goes to requester pointer+1. flush_i in IDLE with req 1 valid → req_rdy_o = 0 that cycle.
- Illegal type and reset: access type 3 with entry 0 matching, fail 0 → fault 1. rstn dropped while in RESP → resp_vld_o = 0 immediately; after release, state is IDLE and the RR pointer is 0.

Source files
------------

// File: rtl/rvh_pmp_check_sched.sv
// rtl/rvh_pmp_check_sched.sv - round-robin scheduler sharing one PMP check port among requesters
// Accepts one request, drives a one-cycle check, returns the resolved fault to the requester.
module rvh_pmp_check_sched #(
  parameter int REQ_NUM     = 3,
  parameter int ENTRY_NUM   = 16,
  parameter int PADDR_WIDTH = 56
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [REQ_NUM-1:0]             req_vld_i,
  input  logic [REQ_NUM*PADDR_WIDTH-1:0] req_paddr_i,
  input  logic [REQ_NUM*2-1:0]           req_access_type_i,
  input  logic [REQ_NUM-1:0]             req_priv_m_i,
  output logic [REQ_NUM-1:0]             req_rdy_o,
  output logic [REQ_NUM-1:0]             resp_vld_o,
  output logic                           resp_fault_o,
  input  logic [REQ_NUM-1:0]             resp_rdy_i,
  input  logic                           flush_i,
  output logic                           permission_check_vld_o,
  output logic [PADDR_WIDTH-1:0]         permission_check_paddr_o,
  output logic [1:0]                     permission_check_access_type_o,
  input  logic [ENTRY_NUM-1:0]           entry_match_i,
  input  logic [ENTRY_NUM-1:0]           entry_fail_i,
  input  logic [ENTRY_NUM-1:0]           entry_lock_i
);

  localparam int PTR_W = $clog2(REQ_NUM);

  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, grant_q, grant_idx, ptr_next;
  logic                   grant_found, grant_take;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic [1:0]             type_q;
  logic                   priv_m_q, fault_q, fault_d;
  logic                   hit, hit_fail, hit_lock;
  int                     idx;

  // Scan from the round-robin pointer upward with wrap-around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr_q) + i) % REQ_NUM;
      if (!grant_found && req_vld_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;

  // Walk high to low so the lowest-numbered matching entry is left standing.
  always_comb begin
    hit      = 1'b0;
    hit_fail = 1'b0;
    hit_lock = 1'b0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (entry_match_i[i]) begin
        hit      = 1'b1;
        hit_fail = entry_fail_i[i];
        hit_lock = entry_lock_i[i];
      end
    end
    if (type_q == 2'd3)          fault_d = 1'b1;
    else if (!hit)               fault_d = ~priv_m_q;
    else if (priv_m_q && !hit_lock) fault_d = 1'b0;
    else                         fault_d = hit_fail;
  end

  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found && !flush_i) begin
          grant_take = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK:   state_d = flush_i ? IDLE : RESP;
      RESP:    if (flush_i || resp_rdy_i[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      paddr_q  <= '0;
      type_q   <= '0;
      priv_m_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        ptr_q    <= ptr_next;
        grant_q  <= grant_idx;
        paddr_q  <= req_paddr_i[int'(grant_idx)*PADDR_WIDTH +: PADDR_WIDTH];
        type_q   <= req_access_type_i[int'(grant_idx)*2 +: 2];
        priv_m_q <= req_priv_m_i[grant_idx];
      end
      if (state_q == CHECK && !flush_i) fault_q <= fault_d;
    end
  end

  always_comb begin
    req_rdy_o  = '0;
    resp_vld_o = '0;
    if (grant_take)       req_rdy_o[grant_idx] = 1'b1;
    if (state_q == RESP)  resp_vld_o[grant_q]  = 1'b1;
  end

  assign resp_fault_o                   = (state_q == RESP) & fault_q;
  assign permission_check_vld_o         = (state_q == CHECK);
  assign permission_check_paddr_o       = paddr_q;
  assign permission_check_access_type_o = type_q;

endmodule

// File: tb/tb_rvh_pmp_check_sched.sv
// tb/tb_rvh_pmp_check_sched.sv - self-checking bench for rvh_pmp_check_sched
// Vector table for single-request resolution, hand sequences for arbitration, flush and reset.
module tb_rvh_pmp_check_sched;
  localparam int RN = 3;
  localparam int EN = 16;
  localparam int PW = 56;

  logic            clk = 1'b0;
  logic            rstn;
  logic [RN-1:0]   req_vld;
  logic [RN*PW-1:0] req_paddr;
  logic [RN*2-1:0] req_type;
  logic [RN-1:0]   req_priv_m;
  logic [RN-1:0]   req_rdy;
  logic [RN-1:0]   resp_vld;
  logic            resp_fault;
  logic [RN-1:0]   resp_rdy;
  logic            flush;
  logic            chk_vld;
  logic [PW-1:0]   chk_paddr;
  logic [1:0]      chk_type;
  logic [EN-1:0]   e_match, e_fail, e_lock;

  rvh_pmp_check_sched #(.REQ_NUM(RN), .ENTRY_NUM(EN), .PADDR_WIDTH(PW)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld_i(req_vld), .req_paddr_i(req_paddr), .req_access_type_i(req_type),
    .req_priv_m_i(req_priv_m), .req_rdy_o(req_rdy),
    .resp_vld_o(resp_vld), .resp_fault_o(resp_fault), .resp_rdy_i(resp_rdy),
    .flush_i(flush),
    .permission_check_vld_o(chk_vld), .permission_check_paddr_o(chk_paddr),
    .permission_check_access_type_o(chk_type),
    .entry_match_i(e_match), .entry_fail_i(e_fail), .entry_lock_i(e_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [PW-1:0] paddr;
    logic [1:0] atype;
    logic       privm;
    logic [EN-1:0] match;
    logic [EN-1:0] fail;
    logic [EN-1:0] lock;
    logic       fault;
  } vec_t;

  typedef struct {
    int   k;
    logic fault;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RN-1:0] oh(input int k);
    logic [RN-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic check_resp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 64'(resp_vld), 64'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_vld"}, 64'(resp_vld), 64'(oh(e.k)));
      chk({name, "_fault"}, 64'(resp_fault), 64'(e.fault));
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One isolated request: grant, check cycle, response, acceptance.
  task automatic run_vec(input vec_t v, input int n);
    int w;
    string nm;
    nm = $sformatf("vec%0d", n);
    @(negedge clk);
    req_paddr[v.k*PW +: PW] = v.paddr;
    req_type[v.k*2 +: 2]    = v.atype;
    req_priv_m[v.k]         = v.privm;
    req_vld[v.k]            = 1'b1;
    sb.push_back('{k: v.k, fault: v.fault});
    #1;
    w = 0;
    while (req_rdy[v.k] !== 1'b1 && w < 10) begin
      @(negedge clk); #1; w++;
    end
    chk({nm, "_rdy"}, 64'(req_rdy), 64'(oh(v.k)));
    @(negedge clk);
    req_vld = '0;
    e_match = v.match; e_fail = v.fail; e_lock = v.lock;
    #1;
    chk({nm, "_chk_vld"}, 64'(chk_vld), 64'd1);
    chk({nm, "_chk_paddr"}, 64'(chk_paddr), 64'(v.paddr));
    chk({nm, "_chk_type"}, 64'(chk_type), 64'(v.atype));
    @(negedge clk);
    e_match = '0; e_fail = '0; e_lock = '0;
    #1;
    check_resp(nm);
    resp_rdy[v.k] = 1'b1;
    @(negedge clk);
    resp_rdy = '0;
    #1;
    chk({nm, "_vld_clr"}, 64'(resp_vld), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 56'h8000_1000, 2'd0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1, 56'h8000_2000, 2'd0, 1'b0, 16'h0014, 16'h0010, 16'h0000, 1'b0};
    vecs[2] = '{2, 56'h8000_3000, 2'd1, 1'b0, 16'h0010, 16'h0010, 16'h0000, 1'b1};
    vecs[3] = '{0, 56'h1234_5678, 2'd0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{1, 56'h00ab_cdef, 2'd0, 1'b1, 16'h0008, 16'h0008, 16'h0000, 1'b0};
    vecs[5] = '{2, 56'h00ab_cdef, 2'd0, 1'b1, 16'h0008, 16'h0008, 16'h0008, 1'b1};
    vecs[6] = '{0, 56'hff_ffff_ffff_fff0, 2'd2, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{1, 56'h4000_0000, 2'd3, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b1};
    vecs[8] = '{2, 56'h5000_0000, 2'd1, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0};
    vecs[9] = '{0, 56'h6000_0000, 2'd2, 1'b0, 16'h8001, 16'h0001, 16'h0000, 1'b1};

    req_vld = '0; req_paddr = '0; req_type = '0; req_priv_m = '0;
    resp_rdy = '0; flush = 1'b0; e_match = '0; e_fail = '0; e_lock = '0;
    rstn = 1'b0;
    #12;
    chk("rst_rdy", 64'(req_rdy), 64'd0);
    chk("rst_resp_vld", 64'(resp_vld), 64'd0);
    chk("rst_chk_vld", 64'(chk_vld), 64'd0);
    chk("rst_chk_paddr", 64'(chk_paddr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_fault", 64'(resp_fault), 64'd0);
    chk("post_rst_type", 64'(chk_type), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Round-robin with all requesters valid from pointer 0 and a stalled response.
    do_reset();
    for (int k = 0; k < RN; k++) req_paddr[k*PW +: PW] = 56'h100 * (k + 1);
    req_type = '0; req_priv_m = '0; req_vld = '1;
    #1;
    chk("rr_g0", 64'(req_rdy), 64'(oh(0)));
    sb.push_back('{k: 0, fault: 1'b1});
    @(negedge clk); #1;
    chk("rr_chk_rdy0", 64'(req_rdy), 64'd0);
    chk("rr_chk_paddr", 64'(chk_paddr), 64'h100);
    @(negedge clk); #1;
    check_resp("rr_r0");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rr_hold%0d_vld", c), 64'(resp_vld), 64'(oh(0)));
      chk($sformatf("rr_hold%0d_fault", c), 64'(resp_fault), 64'd1);
      chk($sformatf("rr_hold%0d_rdy", c), 64'(req_rdy), 64'd0);
    end
    resp_rdy = '1;
    for (int g = 1; g <= 3; g++) begin
      @(negedge clk); #1;
      chk($sformatf("rr_g%0d", g), 64'(req_rdy), 64'(oh(g % RN)));
      sb.push_back('{k: g % RN, fault: 1'b1});
      @(negedge clk); #1;
      chk($sformatf("rr_g%0d_chk", g), 64'(chk_vld), 64'd1);
      @(negedge clk); #1;
      check_resp($sformatf("rr_r%0d", g));
    end

    // Flush in CHECK: pointer is now 1, so grant 1, flush, then grant 2.
    @(negedge clk); #1;
    chk("fl_g1", 64'(req_rdy), 64'(oh(1)));
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_chk_vld", 64'(chk_vld), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_no_resp", 64'(resp_vld), 64'd0);
    chk("fl_next_g2", 64'(req_rdy), 64'(oh(2)));
    sb.push_back('{k: 2, fault: 1'b1});
    @(negedge clk);
    req_vld = '0;
    @(negedge clk); #1;
    check_resp("fl_r2");
    @(negedge clk);
    req_vld = 3'b010;
    flush = 1'b1;
    #1;
    chk("fl_idle_mask", 64'(req_rdy), 64'd0);
    flush = 1'b0;
    #1;
    chk("fl_idle_unmask", 64'(req_rdy), 64'(oh(1)));
    req_vld = '0;
    resp_rdy = '0;

    // Reset while in RESP after granting requester 1 (pointer would be 2).
    @(negedge clk);
    req_vld = 3'b010;
    #1;
    chk("rs_g1", 64'(req_rdy), 64'(oh(1)));
    @(negedge clk);
    req_vld = '0;
    @(negedge clk); #1;
    chk("rs_resp", 64'(resp_vld), 64'(oh(1)));
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_async_vld", 64'(resp_vld), 64'd0);
    chk("rs_async_fault", 64'(resp_fault), 64'd0);
    chk("rs_async_paddr", 64'(chk_paddr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    req_vld = '1;
    #1;
    chk("rs_ptr0", 64'(req_rdy), 64'(oh(0)));
    req_vld = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
